// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples SCLK/CS_n/MOSI in the wb_clk_i domain and exchanges
// MSB-first bytes through single-entry TX and RX holding registers.
module spi_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic       wb_clk_i,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oeb,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic       active
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
  logic                   sclk_hist_q, cs_hist_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_out_q, shift_out_d;
  logic [6:0]  shift_in_q, shift_in_d;
  logic [7:0]  tx_buf_q, tx_buf_d;
  logic        tx_empty_q, tx_empty_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic        armed_q, armed_d;
  logic        reload, byte_done;

  // fill_q marks when the synchronizers hold real samples rather than reset values,
  // so a CS_n held low across reset release cannot arm the target.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_out_d = shift_out_q;
    shift_in_d  = shift_in_q;
    tx_buf_d    = tx_buf_q;
    tx_empty_d  = tx_empty_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
    reload      = 1'b0;
    byte_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall && armed_q) begin
          state_d   = StShift;
          bit_cnt_d = 3'd0;
          reload    = 1'b1;
        end
      end
      StShift: begin
        // A CS_n rise takes priority over any coincident SCLK edge.
        if (cs_rise) begin
          state_d   = StIdle;
          bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
          shift_in_d = {shift_in_q[5:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          byte_done  = (bit_cnt_q == 3'd7);
        end else if (sclk_fall) begin
          if (bit_cnt_q == 3'd0) reload = 1'b1;
          else                   shift_out_d = {shift_out_q[6:0], 1'b0};
        end
      end
      default: state_d = StIdle;
    endcase

    // The shifter always sees the pre-load buffer; a coincident tx_load lands afterwards.
    if (reload) begin
      shift_out_d = tx_empty_q ? FILL_BYTE : tx_buf_q;
      tx_empty_d  = 1'b1;
    end
    if (tx_load) begin
      tx_buf_d   = tx_data;
      tx_empty_d = 1'b0;
    end

    if (rx_ack)  rx_valid_d = 1'b0;
    if (ovr_clr) overrun_d  = 1'b0;
    if (byte_done) begin
      rx_data_d  = {shift_in_q, mosi_s};
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_out_q <= 8'h00;
      shift_in_q  <= 7'h00;
      tx_buf_q    <= 8'h00;
      tx_empty_q  <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_out_q <= shift_out_d;
      shift_in_q  <= shift_in_d;
      tx_buf_q    <= tx_buf_d;
      tx_empty_q  <= tx_empty_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      armed_q     <= armed_d;
    end
  end

  assign active   = (state_q == StShift);
  assign miso_oeb = ~active;
  assign miso     = active ? shift_out_q[7] : 1'b1;
  assign tx_empty = tx_empty_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a cycle-timed SPI master model drives frames and
// hand-computed expectations are compared through a single check task.
module tb_spi_target;

  localparam int unsigned SS = 2;
  localparam int          H  = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, cs_n, mosi;
  logic       miso, miso_oeb;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_empty;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ack;
  logic       overrun, ovr_clr;
  logic       active;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] r1, r2, r3;

  spi_target #(.SYNC_STAGES(SS), .FILL_BYTE(8'hFF)) dut (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oeb (miso_oeb),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_empty (tx_empty),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr),
    .active   (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1; tick(1); rx_ack = 1'b0; tick(1);
  endtask

  task automatic frame_begin();
    cs_n = 1'b0; tick(H);
  endtask

  task automatic frame_end();
    cs_n = 1'b1; tick(H);
  endtask

  // Shifts the top nbits of tx; miso is sampled just before each rising SCLK.
  // ack_last/load_last align a strobe with the DUT's action cycle for the last edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit ack_last,
                      input bit load_last, input logic [7:0] load_val,
                      output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      tick(H);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      if (ack_last && i == nbits - 1) begin
        tick(SS); rx_ack = 1'b1; tick(1); rx_ack = 1'b0; tick(H - SS - 1);
      end else begin
        tick(H);
      end
      sclk = 1'b0;
      if (load_last && i == nbits - 1) begin
        tick(SS); tx_data = load_val; tx_load = 1'b1; tick(1); tx_load = 1'b0; tick(H - SS - 1);
      end else begin
        tick(H);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_load = 1'b0; rx_ack = 1'b0; ovr_clr = 1'b0;
    tick(4);
    check("rst_miso", miso, 1);
    check("rst_oeb", miso_oeb, 1);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_active", active, 0);
    rst_n = 1'b1;
    tick(5);

    // 1: TX byte loaded and sent
    tx_data = 8'hA5; tx_load = 1'b1; tick(1); tx_load = 1'b0;
    check("t1_tx_full", tx_empty, 0);
    frame_begin();
    check("t1_active", active, 1);
    check("t1_oeb_drive", miso_oeb, 0);
    xfer(8'h3C, 8, 1'b0, 1'b0, 8'h00, r1);
    frame_end();
    check("t1_miso_byte", r1, 8'hA5);
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_rx_valid", rx_valid, 1);
    check("t1_tx_empty", tx_empty, 1);
    check("t1_oeb_idle", miso_oeb, 1);
    check("t1_miso_idle", miso, 1);
    pulse_ack();
    check("t1_ack", rx_valid, 0);

    // 2: fill byte and overrun
    frame_begin();
    xfer(8'h11, 8, 1'b0, 1'b0, 8'h00, r1);
    xfer(8'h22, 8, 1'b0, 1'b0, 8'h00, r2);
    frame_end();
    check("t2_fill0", r1, 8'hFF);
    check("t2_fill1", r2, 8'hFF);
    check("t2_rx_data", rx_data, 8'h22);
    check("t2_overrun", overrun, 1);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0; tick(1);
    check("t2_ovr_clr", overrun, 0);
    pulse_ack();

    // 3: abort after 5 bits, then a clean byte
    frame_begin();
    xfer(8'hB0, 5, 1'b0, 1'b0, 8'h00, r1);
    frame_end();
    check("t3_abort_valid", rx_valid, 0);
    frame_begin();
    xfer(8'h81, 8, 1'b0, 1'b0, 8'h00, r1);
    frame_end();
    check("t3_rx_data", rx_data, 8'h81);
    check("t3_rx_valid", rx_valid, 1);

    // 4: rx_ack coincident with completion while rx_valid is set
    frame_begin();
    xfer(8'h5A, 8, 1'b1, 1'b0, 8'h00, r1);
    frame_end();
    check("t4_rx_valid", rx_valid, 1);
    check("t4_rx_data", rx_data, 8'h5A);
    check("t4_overrun", overrun, 0);

    // 5: reset mid-frame with cs_n held low across release
    frame_begin();
    xfer(8'hE0, 3, 1'b0, 1'b0, 8'h00, r1);
    rst_n = 1'b0; tick(3); rst_n = 1'b1; tick(1);
    xfer(8'hAA, 8, 1'b0, 1'b0, 8'h00, r1);
    check("t5_rx_valid", rx_valid, 0);
    check("t5_oeb", miso_oeb, 1);
    check("t5_active", active, 0);
    frame_end();
    frame_begin();
    xfer(8'hC3, 8, 1'b0, 1'b0, 8'h00, r1);
    frame_end();
    check("t5_rx_data", rx_data, 8'hC3);
    check("t5_rx_valid2", rx_valid, 1);
    pulse_ack();

    // 6: tx_load on the byte-boundary reload cycle
    frame_begin();
    xfer(8'h01, 8, 1'b0, 1'b1, 8'h77, r1);
    xfer(8'h02, 8, 1'b0, 1'b0, 8'h00, r2);
    xfer(8'h03, 8, 1'b0, 1'b0, 8'h00, r3);
    frame_end();
    check("t6_byte1", r1, 8'hFF);
    check("t6_byte2", r2, 8'hFF);
    check("t6_byte3", r3, 8'h77);
    check("t6_tx_empty", tx_empty, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
